// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - 4096x32 data-memory responder with 2-cycle read latency, zeroing sweep and preload port
module data_mem_responder #(
    parameter int ADDR_W       = 12,
    parameter int DATA_W       = 32,
    parameter int DEPTH        = 4096,
    parameter int CLEAR_ON_RST = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cen,
    input  logic              wen,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    output logic              ready,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_drop
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_READY = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] clr_ptr;

    logic [DATA_W-1:0] mem [DEPTH];

    // Single write port shared by the sweep, processor writes and preloads
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic              rd_en;
    logic              clr_en;
    logic              drop_nxt;

    logic [DATA_W-1:0] stage1;
    logic              stage1_vld;

    // State register: reset always returns to CLEAR so a sweep restarts from the top
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_CLEAR;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: leave CLEAR once the last word is zeroed, or immediately if no sweep
    always_comb begin
        state_nxt = state;
        case (state)
            S_CLEAR: begin
                if (CLEAR_ON_RST == 0) begin
                    state_nxt = S_READY;
                end else if (clr_ptr == LAST_ADDR) begin
                    state_nxt = S_READY;
                end
            end
            S_READY: state_nxt = S_READY;
            default: state_nxt = S_CLEAR;
        endcase
    end

    // Output/decode logic: processor access has priority over a preload in the same cycle
    always_comb begin
        ready     = 1'b0;
        clr_en    = 1'b0;
        mem_we    = 1'b0;
        mem_waddr = clr_ptr;
        mem_wdata = '0;
        rd_en     = 1'b0;
        drop_nxt  = 1'b0;
        case (state)
            S_CLEAR: begin
                clr_en    = (CLEAR_ON_RST != 0);
                mem_we    = clr_en;
                mem_waddr = clr_ptr;
                mem_wdata = '0;
            end
            S_READY: begin
                ready = 1'b1;
                if (!cen) begin
                    drop_nxt = ld_en;
                    if (!wen) begin
                        mem_we    = 1'b1;
                        mem_waddr = addr;
                        mem_wdata = din;
                    end else begin
                        rd_en = 1'b1;
                    end
                end else if (ld_en) begin
                    mem_we    = 1'b1;
                    mem_waddr = ld_addr;
                    mem_wdata = ld_data;
                end
            end
            default: ready = 1'b0;
        endcase
    end

    // Sweep pointer: wraps back to 0 after the last word, reset restarts it
    always_ff @(posedge clk) begin
        if (rst) begin
            clr_ptr <= '0;
        end else if (clr_en) begin
            clr_ptr <= clr_ptr + 1'b1;
        end
    end

    // Array write port; nothing is written on a reset edge
    always_ff @(posedge clk) begin
        if (!rst && mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // Read pipe: array-output register, then delay register; dout holds between reads
    always_ff @(posedge clk) begin
        if (rst) begin
            stage1     <= '0;
            stage1_vld <= 1'b0;
            dout       <= '0;
            dout_valid <= 1'b0;
            ld_drop    <= 1'b0;
        end else begin
            stage1_vld <= rd_en;
            if (rd_en) begin
                stage1 <= mem[addr];
            end
            dout_valid <= stage1_vld;
            if (stage1_vld) begin
                dout <= stage1;
            end
            ld_drop <= drop_nxt;
        end
    end

endmodule
